// File: rtl/writeback_unit.sv
// rtl/writeback_unit.sv - writeback stage: register-file writes, memory load/store, timeout abort
//
// Ports:
//   clk, reset          clock; asynchronous active-low reset
//   valid_in, ready     instruction handshake (ready only in IDLE)
//   opcode_in, alu_res, ra_in   presented instruction, ALU result, store data
//   mem_req, mem_we, mem_addr, mem_wdata, mem_rdata, mem_ack   memory port
//   we, opcode_out, data_out    register-file write port
//   err                 sticky memory-timeout flag
//   retire_cnt          retired-instruction counter (wraps)

module writeback_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready,
    input  logic [15:0] opcode_in,
    input  logic [7:0]  alu_res,
    input  logic [7:0]  ra_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [7:0]  mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        we,
    output logic [15:0] opcode_out,
    output logic [7:0]  data_out,
    output logic        err,
    output logic [15:0] retire_cnt
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MEM_RD = 2'd1,
        MEM_WR = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t         state, state_d;
    logic [15:0]    op_q;
    logic [CW-1:0]  wait_cnt;
    logic [3:0]     cls;
    logic           cls_alu;
    logic           cls_imm;
    logic           cls_ld;
    logic           cls_st;
    logic           in_mem;
    logic           timeout_hit;
    logic           retire_inc;

    assign cls     = opcode_in[15:12];
    assign cls_alu = (cls >= 4'h1) && (cls <= 4'h6);
    assign cls_imm = (cls == 4'hF);
    assign cls_ld  = (cls == 4'hD);
    assign cls_st  = (cls == 4'h7);

    assign in_mem = (state == MEM_RD) || (state == MEM_WR);
    // The wait counter holds the number of completed wait cycles; the edge that
    // closes cycle number TIMEOUT aborts unless an ack is sampled on it.
    assign timeout_hit = in_mem && !mem_ack && (wait_cnt == CW'(TIMEOUT - 1));

    assign ready   = (state == IDLE);
    assign we      = (state == WRITE);
    assign mem_req = in_mem;
    assign mem_we  = (state == MEM_WR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        retire_inc = 1'b0;
        case (state)
            IDLE: begin
                if (valid_in) begin
                    if (cls_alu || cls_imm) begin
                        state_d = WRITE;
                    end else if (cls_ld) begin
                        state_d = MEM_RD;
                    end else if (cls_st) begin
                        state_d = MEM_WR;
                    end else begin
                        // Unused classes retire immediately with no side effects.
                        retire_inc = 1'b1;
                    end
                end
            end
            MEM_RD: begin
                if (mem_ack) begin
                    state_d = WRITE;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            MEM_WR: begin
                if (mem_ack) begin
                    state_d    = IDLE;
                    retire_inc = 1'b1;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WRITE: begin
                state_d    = IDLE;
                retire_inc = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q       <= '0;
            wait_cnt   <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            opcode_out <= '0;
            data_out   <= '0;
            err        <= 1'b0;
            retire_cnt <= '0;
        end else begin
            if (retire_inc) begin
                retire_cnt <= retire_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (valid_in) begin
                        op_q <= opcode_in;
                        if (cls_alu) begin
                            opcode_out <= {4'b1101, opcode_in[11:10], 10'b0};
                            data_out   <= alu_res;
                        end else if (cls_imm) begin
                            opcode_out <= opcode_in;
                            data_out   <= opcode_in[7:0];
                        end else if (cls_ld) begin
                            mem_addr <= opcode_in[7:0];
                        end else if (cls_st) begin
                            mem_addr  <= opcode_in[7:0];
                            mem_wdata <= ra_in;
                        end
                    end
                end
                MEM_RD, MEM_WR: begin
                    if (mem_ack) begin
                        wait_cnt <= '0;
                        if (state == MEM_RD) begin
                            data_out   <= mem_rdata;
                            opcode_out <= op_q;
                        end
                    end else if (timeout_hit) begin
                        wait_cnt <= '0;
                        err      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: wait_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// tb/tb_writeback_unit.sv - directed self-checking bench for writeback_unit

module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in;
    logic        ready;
    logic [15:0] opcode_in;
    logic [7:0]  alu_res;
    logic [7:0]  ra_in;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_ack;
    logic        we;
    logic [15:0] opcode_out;
    logic [7:0]  data_out;
    logic        err;
    logic [15:0] retire_cnt;

    int checks   = 0;
    int failures = 0;

    writeback_unit #(.TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .valid_in   (valid_in),
        .ready      (ready),
        .opcode_in  (opcode_in),
        .alu_res    (alu_res),
        .ra_in      (ra_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .we         (we),
        .opcode_out (opcode_out),
        .data_out   (data_out),
        .err        (err),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [15:0] op, input logic [7:0] alu, input logic [7:0] ra);
        opcode_in = op;
        alu_res   = alu;
        ra_in     = ra;
        valid_in  = 1'b1;
        tick();
        valid_in  = 1'b0;
    endtask

    int n;
    int we_seen;

    initial begin
        reset     = 1'b0;
        valid_in  = 1'b0;
        opcode_in = '0;
        alu_res   = '0;
        ra_in     = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        tick();
        tick();
        check("rst_ready", ready, 1);
        check("rst_mem_req", mem_req, 0);
        check("rst_we", we, 0);
        check("rst_err", err, 0);
        check("rst_retire", retire_cnt, 0);
        check("rst_opcode_out", opcode_out, 0);
        reset = 1'b1;
        tick();
        check("post_rst_ready", ready, 1);

        // immediate load
        present(16'hF4A5, 8'h00, 8'h00);
        check("imm_we", we, 1);
        check("imm_opcode", opcode_out, 16'hF4A5);
        check("imm_data", data_out, 8'hA5);
        check("imm_ready", ready, 0);
        tick();
        check("imm_we_off", we, 0);
        check("imm_retire", retire_cnt, 1);
        check("imm_hold_op", opcode_out, 16'hF4A5);

        // ALU writeback
        present(16'h1800, 8'h3C, 8'h00);
        check("alu_we", we, 1);
        check("alu_opcode", opcode_out, 16'hD800);
        check("alu_data", data_out, 8'h3C);
        tick();
        check("alu_we_off", we, 0);
        check("alu_retire", retire_cnt, 2);

        // load with 3-cycle ack delay
        present(16'hD420, 8'h00, 8'h00);
        for (int c = 1; c <= 3; c++) begin
            check("ld_req", mem_req, 1);
            check("ld_addr", mem_addr, 8'h20);
            check("ld_mem_we", mem_we, 0);
            check("ld_ready", ready, 0);
            if (c == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 8'h77;
            end
            tick();
        end
        mem_ack = 1'b0;
        check("ld_req_drop", mem_req, 0);
        check("ld_we", we, 1);
        check("ld_data", data_out, 8'h77);
        check("ld_opcode", opcode_out, 16'hD420);
        tick();
        check("ld_retire", retire_cnt, 3);

        // store; upstream inputs change while waiting but must not disturb the port
        present(16'h7C10, 8'h00, 8'h5A);
        opcode_in = 16'h7CFF;
        ra_in     = 8'h00;
        for (int c = 1; c <= 2; c++) begin
            check("st_req", mem_req, 1);
            check("st_mem_we", mem_we, 1);
            check("st_addr", mem_addr, 8'h10);
            check("st_wdata", mem_wdata, 8'h5A);
            check("st_we", we, 0);
            if (c == 2) mem_ack = 1'b1;
            tick();
        end
        mem_ack = 1'b0;
        check("st_req_drop", mem_req, 0);
        check("st_we_after", we, 0);
        check("st_ready", ready, 1);
        check("st_retire", retire_cnt, 4);

        // unused class retires in place
        present(16'h8000, 8'h11, 8'h22);
        check("nop_ready", ready, 1);
        check("nop_we", we, 0);
        check("nop_req", mem_req, 0);
        check("nop_retire", retire_cnt, 5);

        // timeout with no ack
        present(16'hD455, 8'h00, 8'h00);
        n = 0;
        we_seen = 0;
        while (mem_req && n < 40) begin
            n++;
            if (we) we_seen++;
            tick();
        end
        check("to_req_cycles", n, 15);
        check("to_err", err, 1);
        check("to_we_seen", we_seen, 0);
        check("to_we", we, 0);
        check("to_retire", retire_cnt, 5);
        check("to_ready", ready, 1);
        tick();
        check("to_we_late", we, 0);

        // ack on the last allowed cycle counts as success
        present(16'hD433, 8'h00, 8'h00);
        for (int c = 1; c < 15; c++) tick();
        check("edge_req", mem_req, 1);
        mem_ack   = 1'b1;
        mem_rdata = 8'h99;
        tick();
        mem_ack = 1'b0;
        check("edge_we", we, 1);
        check("edge_data", data_out, 8'h99);
        check("edge_opcode", opcode_out, 16'hD433);
        tick();
        check("edge_retire", retire_cnt, 6);
        check("edge_err_sticky", err, 1);

        // asynchronous reset mid-load
        present(16'hD4AA, 8'h00, 8'h00);
        check("mid_req", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_req", mem_req, 0);
        check("mid_rst_mem_we", mem_we, 0);
        check("mid_rst_addr", mem_addr, 0);
        check("mid_rst_opcode", opcode_out, 0);
        check("mid_rst_data", data_out, 0);
        check("mid_rst_err", err, 0);
        check("mid_rst_retire", retire_cnt, 0);
        check("mid_rst_ready", ready, 1);
        tick();
        reset = 1'b1;
        tick();
        check("mid_post_ready", ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 The block SHALL provide parameter TIMEOUT, default 15, the maximum number of cycles to wait for mem_ack before aborting.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-004 valid_in  input  1  an instruction is presented on opcode_in/alu_res/ra_in.
REQ-005 ready  output  1  block can accept an instruction this cycle.
REQ-006 opcode_in  input  16  instruction word: [15:12] class, [11:10] destination/source register, [7:0] immediate or address.
REQ-007 alu_res  input  8  ALU result for the presented instruction.
REQ-008 ra_in  input  8  Ra operand, the store data for stores.
REQ-009 mem_req  output  1  memory access request, held until acknowledged or aborted.
REQ-010 mem_we  output  1  1 = memory write, 0 = memory read; valid while mem_req=1.
REQ-011 mem_addr  output  8  memory address.
REQ-012 mem_wdata  output  8  memory write data.
REQ-013 mem_rdata  input  8  memory read data; valid when mem_ack=1.
REQ-014 mem_ack  input  1  memory completes the access; sampled on the rising edge.
REQ-015 we  output  1  register-file write enable.
REQ-016 opcode_out  output  16  register-file opcode: class 1101 selects a data load, class 1111 an immediate load.
REQ-017 data_out  output  8  register-file write data.
REQ-018 err  output  1  sticky memory-timeout flag.
REQ-019 retire_cnt  output  16  count of retired instructions.

Function
REQ-020 The block SHALL implement a state machine with states IDLE, MEM_RD, MEM_WR and WRITE; ready SHALL be 1 only in IDLE.
REQ-021 In IDLE, when valid_in=1 the block SHALL latch opcode_in, alu_res and ra_in at the rising edge; when valid_in=0 it SHALL stay in IDLE.
REQ-022 Classes 0001-0110 SHALL go to WRITE with opcode_out={4'b1101, opcode_in[11:10], 10'b0} and data_out=alu_res.
REQ-023 Class 1111 SHALL go to WRITE with opcode_out=opcode_in and data_out=opcode_in[7:0].
REQ-024 Class 1101 SHALL go to MEM_RD with mem_req=1, mem_we=0 and mem_addr=opcode_in[7:0].
REQ-025 Class 0111 SHALL go to MEM_WR with mem_req=1, mem_we=1, mem_addr=opcode_in[7:0] and mem_wdata=ra_in.
REQ-026 All other classes (0000, 1000-1100, 1110) SHALL be consumed with no write and no memory access, stay in IDLE and increment retire_cnt.
REQ-027 mem_req SHALL be asserted from the cycle after acceptance and SHALL stay high, with address and data stable, until mem_ack is sampled high or the access times out.
REQ-028 In MEM_RD, mem_ack=1 SHALL capture mem_rdata into data_out, set opcode_out=opcode_in (class 1101), drop mem_req and go to WRITE.
REQ-029 In MEM_WR, mem_ack=1 SHALL drop mem_req, return to IDLE and increment retire_cnt; no register write SHALL occur.
REQ-030 A wait counter SHALL count cycles spent in MEM_RD or MEM_WR.
REQ-031 If the wait counter reaches TIMEOUT with no mem_ack, the block SHALL drop mem_req, set err=1, return to IDLE, perform no register write and not increment retire_cnt.
REQ-032 An ack arriving on the same cycle the count reaches TIMEOUT SHALL be treated as success.
REQ-033 WRITE SHALL last exactly one cycle with we=1, then return to IDLE and increment retire_cnt.
REQ-034 we SHALL be 0 in every other state, and opcode_out and data_out SHALL hold their last values.
REQ-035 Latency SHALL be: ALU and immediate instructions accepted at edge N drive we=1 between edges N+1 and N+2; a load writes back one cycle after its ack edge.
REQ-036 retire_cnt SHALL wrap from 16'hFFFF to 0.
REQ-037 err SHALL clear only on reset.
REQ-038 valid_in when ready=0 SHALL be ignored, and the upstream stage SHALL hold the instruction until ready=1.

Reset
REQ-039 Asserting reset (reset=0) at any time, including mid-access, SHALL immediately force state IDLE, mem_req=0, mem_we=0, we=0, and mem_addr, mem_wdata, opcode_out, data_out, err, retire_cnt and the wait counter all to 0.
REQ-040 On release of reset, ready SHALL be 1 from the first cycle.

Verification
REQ-041 Immediate load: opcode_in=16'hF4A5 with valid_in=1 for one cycle -> next cycle we=1, opcode_out=16'hF4A5, data_out=8'hA5; retire_cnt=1 after that cycle.
REQ-042 ALU writeback: opcode_in=16'h1800, alu_res=8'h3C -> we=1 for one cycle, opcode_out=16'hD800, data_out=8'h3C.
REQ-043 Load with 3-cycle ack delay: opcode_in=16'hD420, mem_rdata=8'h77 -> mem_req=1 and mem_addr=8'h20 held for 3 cycles with ready=0; one cycle after the ack, we=1, data_out=8'h77, opcode_out=16'hD420.
REQ-044 Store: opcode_in=16'h7C10, ra_in=8'h5A -> mem_req=1, mem_we=1, mem_addr=8'h10, mem_wdata=8'h5A until ack; we stays 0 throughout.
REQ-045 Timeout: a load with mem_ack tied to 0 -> mem_req drops after 15 cycles, err=1, no we pulse, retire_cnt unchanged.
REQ-046 Reset mid-load: reset=0 while mem_req=1 -> mem_req=0 and all outputs 0 immediately, without waiting for a clock edge.
